// File: rtl/instr_fetch_queue_pkg.sv
// instr_fetch_queue_pkg: shared fetch width, NOP encoding and slot record {pc, instr, filled}
package instr_fetch_queue_pkg;
  localparam int FQ_XLEN = 32;
  localparam logic [FQ_XLEN-1:0] NOP = 32'h0000_0013;
  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] instr;
    logic               filled;
  } slot_t;
endpackage

// File: rtl/fq_slot_ram.sv
// fq_slot_ram: DEPTH slot array; alloc port (idx, pc) clears filled, fill port (idx, data) sets it, flush/reset clear all filled bits, async read at rd_idx
module fq_slot_ram
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN = FQ_XLEN,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            alloc_en,
  input  logic [AW-1:0]   alloc_idx,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill_en,
  input  logic [AW-1:0]   fill_idx,
  input  logic [XLEN-1:0] fill_data,
  input  logic [AW-1:0]   rd_idx,
  output logic [XLEN-1:0] rd_pc,
  output logic [XLEN-1:0] rd_instr,
  output logic            rd_filled
);
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [DEPTH-1:0] filled;
  always_ff @(posedge clock) begin
    if (alloc_en) pc_mem[alloc_idx] <= alloc_pc;
    if (fill_en) instr_mem[fill_idx] <= fill_data;
  end
  always_ff @(posedge clock) begin
    if (reset || flush) filled <= '0;
    else begin
      if (alloc_en) filled[alloc_idx] <= 1'b0;
      if (fill_en) filled[fill_idx] <= 1'b1;
    end
  end
  assign rd_pc = pc_mem[rd_idx];
  assign rd_instr = instr_mem[rd_idx];
  assign rd_filled = filled[rd_idx];
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: turns io_pc into in-order imem requests, queues tagged responses, presents {pc, instr} to decode; stall/flush/sticky-err control
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN = FQ_XLEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] io_pc,
  output logic            io_stall_en,
  output logic            io_imem_req_valid,
  input  logic            io_imem_req_ready,
  output logic [XLEN-1:0] io_imem_req_addr,
  input  logic            io_imem_rsp_valid,
  input  logic [XLEN-1:0] io_imem_rsp_data,
  output logic            io_out_valid,
  input  logic            io_out_ready,
  output logic [XLEN-1:0] io_out_pc,
  output logic [XLEN-1:0] io_out_instr,
  input  logic            io_flush,
  output logic            io_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] FULL = (CW+1)'(DEPTH);
  logic [AW-1:0] head, fill, tail;
  logic [CW-1:0] alloc_cnt, drop_cnt, unf_cnt;
  logic [CW:0] used, flush_drops;
  logic fire, pop, dropping, fill_en, stray, head_filled, err;
  assign used = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
  assign flush_drops = {1'b0, drop_cnt} + {1'b0, unf_cnt};
  assign io_imem_req_valid = !reset && !io_flush && (used < FULL);
  assign io_imem_req_addr = io_pc;
  assign fire = io_imem_req_valid && io_imem_req_ready;
  assign io_stall_en = !fire;
  assign io_out_valid = !reset && (alloc_cnt != '0) && head_filled;
  assign pop = io_out_valid && io_out_ready && !io_flush;
  assign dropping = io_imem_rsp_valid && (drop_cnt != '0);
  assign fill_en = io_imem_rsp_valid && !reset && !io_flush && (drop_cnt == '0) && (unf_cnt != '0);
  // a response with no pending drop and no unfilled slot has no owner; in a flush cycle it would otherwise be charged to the drops
  assign stray = io_imem_rsp_valid && (io_flush ? (flush_drops == '0) : (drop_cnt == '0 && unf_cnt == '0));
  assign io_err = !reset && err;
  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      fill <= '0;
      tail <= '0;
      alloc_cnt <= '0;
      drop_cnt <= '0;
      unf_cnt <= '0;
      err <= 1'b0;
    end else begin
      if (stray) err <= 1'b1;
      if (io_flush) begin
        head <= '0;
        fill <= '0;
        tail <= '0;
        alloc_cnt <= '0;
        unf_cnt <= '0;
        // unfilled slots still have responses coming; one arriving now is already accounted for
        drop_cnt <= CW'(flush_drops - {{CW{1'b0}}, io_imem_rsp_valid && !stray});
      end else begin
        if (fire) tail <= tail + AW'(1);
        if (pop) head <= head + AW'(1);
        if (fill_en) fill <= fill + AW'(1);
        if (dropping) drop_cnt <= drop_cnt - CW'(1);
        alloc_cnt <= alloc_cnt + CW'(fire) - CW'(pop);
        unf_cnt <= unf_cnt + CW'(fire) - CW'(fill_en);
      end
    end
  end
  fq_slot_ram #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) u_ram (
    .clock(clock),
    .reset(reset),
    .flush(io_flush),
    .alloc_en(fire),
    .alloc_idx(tail),
    .alloc_pc(io_pc),
    .fill_en(fill_en),
    .fill_idx(fill),
    .fill_data(io_imem_rsp_data),
    .rd_idx(head),
    .rd_pc(io_out_pc),
    .rd_instr(io_out_instr),
    .rd_filled(head_filled)
  );
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed stimulus with in-order memory model; scoreboard monitor checks every popped {pc, instr}
module tb_instr_fetch_queue;
  import instr_fetch_queue_pkg::*;
  typedef struct { logic [31:0] data; int due; } mem_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [31:0] io_pc;
  logic io_stall_en, io_imem_req_valid, io_imem_req_ready;
  logic [31:0] io_imem_req_addr;
  logic io_imem_rsp_valid;
  logic [31:0] io_imem_rsp_data;
  logic io_out_valid, io_out_ready;
  logic [31:0] io_out_pc, io_out_instr;
  logic io_flush, io_err;
  slot_t sb[$];
  mem_t mem_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 1;
  logic s_fire, s_stall, s_reqv, s_outv, s_err, s_rspv;
  logic [31:0] s_pc, s_outpc, s_outinstr;
  instr_fetch_queue dut (
    .clock(clock),
    .reset(reset),
    .io_pc(io_pc),
    .io_stall_en(io_stall_en),
    .io_imem_req_valid(io_imem_req_valid),
    .io_imem_req_ready(io_imem_req_ready),
    .io_imem_req_addr(io_imem_req_addr),
    .io_imem_rsp_valid(io_imem_rsp_valid),
    .io_imem_rsp_data(io_imem_rsp_data),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .io_out_pc(io_out_pc),
    .io_out_instr(io_out_instr),
    .io_flush(io_flush),
    .io_err(io_err)
  );
  always #5 clock = ~clock;
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return NOP ^ {a[23:0], 8'h00};
  endfunction
  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction
  always @(negedge clock) begin
    slot_t e;
    if (!reset && !io_flush && io_out_valid && io_out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL mon_unexpected: got output pc %h, expected none", io_out_pc);
      end else begin
        e = sb.pop_front();
        chk("mon_pc", io_out_pc, e.pc);
        chk("mon_instr", io_out_instr, e.instr);
      end
    end
  end
  task automatic cycle();
    mem_t m;
    @(negedge clock);
    s_fire = io_imem_req_valid && io_imem_req_ready;
    s_stall = io_stall_en;
    s_reqv = io_imem_req_valid;
    s_outv = io_out_valid;
    s_err = io_err;
    s_rspv = io_imem_rsp_valid;
    s_pc = io_pc;
    s_outpc = io_out_pc;
    s_outinstr = io_out_instr;
    chk("req_addr", io_imem_req_addr, io_pc);
    if (s_fire) begin
      m.data = instr_of(io_pc);
      m.due = cyc + lat;
      if (mem_q.size() > 0 && mem_q[$].due >= m.due) m.due = mem_q[$].due + 1;
      mem_q.push_back(m);
      sb.push_back('{pc: io_pc, instr: instr_of(io_pc), filled: 1'b1});
    end
    if (io_flush || reset) sb.delete();
    @(posedge clock);
    cyc++;
    #1;
    if (s_fire) io_pc = io_pc + 32'd4;
    io_imem_rsp_valid = 1'b0;
    io_imem_rsp_data = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      io_imem_rsp_valid = 1'b1;
      io_imem_rsp_data = mem_q[0].data;
      void'(mem_q.pop_front());
    end
  endtask
  task automatic wait_out(input string nm, input logic [31:0] pc);
    int k = 0;
    do begin
      cycle();
      k++;
    end while (!s_outv && k < 12);
    chk({nm, "_valid"}, 32'(s_outv), 32'd1);
    chk({nm, "_pc"}, s_outpc, pc);
  endtask
  task automatic drain();
    int k = 0;
    io_imem_req_ready = 1'b0;
    io_out_ready = 1'b1;
    while ((mem_q.size() > 0 || sb.size() > 0) && k < 40) begin
      cycle();
      k++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    int nf;
    io_pc = '0;
    io_imem_req_ready = 1'b0;
    io_imem_rsp_valid = 1'b0;
    io_imem_rsp_data = '0;
    io_out_ready = 1'b0;
    io_flush = 1'b0;
    repeat (2) begin
      cycle();
      chk("rst_stall", 32'(s_stall), 32'd1);
      chk("rst_reqv", 32'(s_reqv), 32'd0);
      chk("rst_outv", 32'(s_outv), 32'd0);
      chk("rst_err", 32'(s_err), 32'd0);
    end
    reset = 1'b0;
    io_pc = 32'h0;
    io_imem_req_ready = 1'b1;
    io_out_ready = 1'b1;
    lat = 1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("t1_stall", 32'(s_stall), 32'd0);
      chk("t1_outv", 32'(s_outv), 32'(i >= 2));
      if (i == 2) chk("t1_first_pc", s_outpc, 32'h0);
    end
    drain();
    io_pc = 32'h0;
    io_imem_req_ready = 1'b1;
    io_out_ready = 1'b0;
    nf = 0;
    repeat (6) begin
      cycle();
      nf += int'(s_fire);
    end
    chk("t2_fires", 32'(nf), 32'd4);
    chk("t2_full_stall", 32'(s_stall), 32'd1);
    chk("t2_full_reqv", 32'(s_reqv), 32'd0);
    chk("t2_pc_held", io_pc, 32'h10);
    io_out_ready = 1'b1;
    cycle();
    chk("t2_pop_stall", 32'(s_stall), 32'd1);
    chk("t2_pop_pc", s_outpc, 32'h0);
    io_out_ready = 1'b0;
    cycle();
    chk("t2_refire", 32'(s_fire), 32'd1);
    chk("t2_refire_pc", s_pc, 32'h10);
    cycle();
    chk("t2_full_again", 32'(s_stall), 32'd1);
    drain();
    io_pc = 32'h20;
    io_imem_req_ready = 1'b0;
    io_out_ready = 1'b1;
    repeat (3) begin
      cycle();
      chk("t3_stall", 32'(s_stall), 32'd1);
    end
    io_imem_req_ready = 1'b1;
    cycle();
    chk("t3_fire", 32'(s_fire), 32'd1);
    chk("t3_fire_pc", s_pc, 32'h20);
    io_imem_req_ready = 1'b0;
    wait_out("t3_out", 32'h20);
    drain();
    io_pc = 32'h40;
    lat = 3;
    io_imem_req_ready = 1'b1;
    io_out_ready = 1'b1;
    repeat (3) cycle();
    io_flush = 1'b1;
    io_pc = 32'h100;
    cycle();
    chk("t4_flush_rsp", 32'(s_rspv), 32'd1);
    chk("t4_flush_stall", 32'(s_stall), 32'd1);
    chk("t4_flush_reqv", 32'(s_reqv), 32'd0);
    io_flush = 1'b0;
    cycle();
    chk("t4_new_fire", 32'(s_fire), 32'd1);
    chk("t4_new_pc", s_pc, 32'h100);
    io_imem_req_ready = 1'b0;
    wait_out("t4_out", 32'h100);
    chk("t4_out_instr", s_outinstr, instr_of(32'h100));
    chk("t4_err", 32'(s_err), 32'd0);
    drain();
    lat = 1;
    io_pc = 32'h200;
    io_imem_req_ready = 1'b1;
    io_out_ready = 1'b0;
    cycle();
    io_imem_req_ready = 1'b0;
    cycle();
    io_imem_rsp_valid = 1'b1;
    io_imem_rsp_data = 32'hDEAD_BEEF;
    cycle();
    chk("t5_err_before", 32'(s_err), 32'd0);
    cycle();
    chk("t5_err_set", 32'(s_err), 32'd1);
    chk("t5_outv", 32'(s_outv), 32'd1);
    chk("t5_outpc", s_outpc, 32'h200);
    chk("t5_outinstr", s_outinstr, instr_of(32'h200));
    drain();
    repeat (2) cycle();
    chk("t5_err_sticky", 32'(s_err), 32'd1);
    io_pc = 32'h300;
    io_imem_req_ready = 1'b1;
    io_out_ready = 1'b0;
    lat = 2;
    cycle();
    cycle();
    lat = 8;
    cycle();
    io_imem_req_ready = 1'b0;
    lat = 1;
    cycle();
    cycle();
    chk("t6_pre_outv", 32'(s_outv), 32'd1);
    chk("t6_pre_outpc", s_outpc, 32'h300);
    reset = 1'b1;
    cycle();
    chk("t6_rst_reqv", 32'(s_reqv), 32'd0);
    chk("t6_rst_stall", 32'(s_stall), 32'd1);
    chk("t6_rst_outv", 32'(s_outv), 32'd0);
    reset = 1'b0;
    cycle();
    chk("t6_post_outv", 32'(s_outv), 32'd0);
    chk("t6_err_cleared", 32'(s_err), 32'd0);
    for (int k = 0; k < 12 && !s_err; k++) cycle();
    chk("t6_late_err", 32'(s_err), 32'd1);
    chk("t6_no_outv", 32'(s_outv), 32'd0);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
Sits directly downstream of the PC generator (FetchUnit). Each cycle it turns the current io_pc into an instruction-memory request. It holds in-order responses in a small slot queue tagged with their PC and presents {pc, instr} to decode with a valid/ready handshake. It drives io_stall_en back to the PC generator whenever the current PC cannot be issued, so the PC holds until accepted.

Parameters:
DEPTH, 4, number of queue slots (power of two, >=2); bounds allocated slots plus responses still to be dropped
XLEN, 32, PC and instruction width

Ports:
clock  in  1  single clock; all state updates on posedge
reset  in  1  synchronous, active-high
io_pc  in  XLEN  current PC from the PC generator
io_stall_en  out  1  1 = PC not accepted this cycle; PC generator must hold
io_imem_req_valid  out  1  fetch request valid
io_imem_req_ready  in  1  memory accepts request
io_imem_req_addr  out  XLEN  request address (= io_pc)
io_imem_rsp_valid  in  1  response valid; responses strictly in request order, latency >=1
io_imem_rsp_data  in  XLEN  instruction word
io_out_valid  out  1  head slot filled
io_out_ready  in  1  decode accepts head
io_out_pc  out  XLEN  PC of head instruction
io_out_instr  out  XLEN  head instruction
io_flush  in  1  discard all queued and in-flight instructions
io_err  out  1  sticky: response arrived with nothing outstanding

Behaviour:
- State: DEPTH slots {pc, instr, filled}. Pointers head, fill, tail (log2 DEPTH bits, wrap modulo DEPTH). alloc_cnt in 0..DEPTH. drop_cnt in 0..DEPTH. Sticky err.
- Reset: pointers, alloc_cnt, drop_cnt, filled bits and err cleared. While reset is high, io_imem_req_valid=0, io_stall_en=1, io_out_valid=0, io_err=0.
- Issue, combinational: io_imem_req_valid = !io_flush && (alloc_cnt + drop_cnt < DEPTH). io_imem_req_addr = io_pc. fire = req_valid && req_ready. io_stall_en = !fire.
- On fire: slot[tail].pc <= io_pc, filled <= 0, tail++, alloc_cnt++.
- Response when drop_cnt > 0: discarded, drop_cnt--.
- Response when drop_cnt == 0 and an unfilled allocated slot exists: slot[fill].instr <= data, filled <= 1, fill++.
- Response when drop_cnt == 0 and no unfilled slot exists: ignored, err <= 1.
- Output is registered only. io_out_valid = (alloc_cnt != 0) && slot[head].filled. A response at cycle t is visible on io_out at t+1 earliest; there is no bypass.
- Pop on io_out_valid && io_out_ready: head++, alloc_cnt--.
- Same-cycle fire, fill and pop all apply. alloc_cnt changes by fire minus pop. A slot can be filled and popped in the same cycle only if it was already filled before that cycle.
- Full (alloc_cnt + drop_cnt == DEPTH): no request issued, io_stall_en=1. A pop that frees space takes effect next cycle; there is no combinational ready-through.
- Flush has priority over fire, fill and pop:
  - Clear all filled bits.
  - head = fill = tail = 0, alloc_cnt = 0.
  - drop_cnt_next = drop_cnt + unfilled_alloc − (rsp_valid ? 1 : 0). A response arriving in the flush cycle is discarded and counts against the pending drops.
  - No request is issued in the flush cycle (stall_en=1).
- The PC is accepted exactly once per fire. The PC generator advances only on cycles where io_stall_en=0.

Decomposition:
- Shared fetch package: XLEN, NOP encoding 32'h00000013 for benches, slot record typedef {pc, instr, filled}.
- One sub-module, fq_slot_ram: DEPTH×(2·XLEN+1) register array with separate alloc/fill/read ports, flush clear of filled bits.
- Pointer and counter control stays in instr_fetch_queue.

Test Plan:
- Reset, then io_pc=0x0, req_ready=1, 1-cycle memory latency, out_ready=1 → outputs in order (0x0,i0),(0x4,i1),(0x8,i2). io_stall_en=0 every cycle after reset. First out_valid 2 cycles after first fire.
- out_ready=0, memory always ready → exactly 4 fires (0x0..0xC), then io_stall_en=1 and req_valid=0. One pop → one further fire the next cycle (PC 0x10).
- req_ready held 0 for 3 cycles with io_pc=0x20 → io_stall_en=1 for 3 cycles. First fire carries 0x20 and out_pc=0x20.
- Three requests in flight (latency 3), flush in cycle with rsp_valid=1 → drop_cnt=2. Next two responses discarded. New request at 0x100 returns and emerges with out_pc=0x100. io_err stays 0.
- Response with nothing outstanding → io_err=1 and sticky until reset. Queue contents unchanged.
- Reset asserted with 2 filled and 1 unfilled slot → next cycle out_valid=0, req_valid=0 during reset. After reset the late response sets io_err=1.
